// File: rtl/macro_pkg.sv
// Shared types for the ALU issue path.
// Holds the opcode enum, the command bundle and ALU width.
package macro_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7
  } opcode_e;

  typedef struct packed {
    opcode_e          ctl;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             cin;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands.
// Uses wrap-bit pointers; flush overrides push and pop.
module alu_cmd_fifo
  import macro_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  alu_cmd_t din,
  output alu_cmd_t dout,
  output logic [AW:0] count,
  output logic     full,
  output logic     empty
);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  alu_cmd_t    r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rptr[AW-1:0]];
  assign count = r_wptr - r_rptr;
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW])
              && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage for the 4-bit ALU: buffers commands and
// issues them as single-cycle pulses, capping in-flight ops.
module alu_issue_queue
  import macro_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = ALU_W,
  parameter int MAX_OUTST = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  opcode_e           cmd_ctl,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_cin,
  input  logic              flush,
  output logic              valid_in,
  output opcode_e           ctl,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              cin,
  input  logic              valid_out,
  output logic [CW-1:0]     count,
  output logic [3:0]        outstanding,
  output logic              err_underflow
);

  localparam logic [3:0] LP_MAX = 4'(MAX_OUTST);

  alu_cmd_t          w_cmd;
  alu_cmd_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_issue;

  logic              r_vin;
  opcode_e           r_ctl;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_cin;
  logic [3:0]        r_outst;
  logic              r_err;

  always_comb begin
    w_cmd     = '0;
    w_cmd.ctl = cmd_ctl;
    w_cmd.a   = cmd_a;
    w_cmd.b   = cmd_b;
    w_cmd.cin = cmd_cin;
  end

  assign cmd_ready = reset && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_issue   = !w_empty && (r_outst < LP_MAX) && !flush;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_issue),
    .flush (flush),
    .din   (w_cmd),
    .dout  (w_head),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vin   <= 1'b0;
      r_ctl   <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_outst <= '0;
      r_err   <= 1'b0;
    end else begin
      r_vin <= w_issue;
      if (w_issue) begin
        r_ctl <= w_head.ctl;
        r_a   <= w_head.a;
        r_b   <= w_head.b;
        r_cin <= w_head.cin;
      end
      // issue and completion on the same edge cancel out
      unique case ({w_issue, valid_out})
        2'b10: r_outst <= r_outst + 4'd1;
        2'b01: begin
          if (r_outst != 4'd0) r_outst <= r_outst - 4'd1;
          else                 r_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign valid_in      = r_vin;
  assign ctl           = r_ctl;
  assign a             = r_a;
  assign b             = r_b;
  assign cin           = r_cin;
  assign outstanding   = r_outst;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: queue-based reference model
// checked every cycle, plus directed literal checks.
module tb_alu_issue_queue;
  import macro_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXO  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  opcode_e    cmd_ctl = OP_ADD;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_cin = 1'b0;
  logic       flush = 1'b0;
  logic       valid_in;
  opcode_e    ctl;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       valid_out;
  logic [3:0] count;
  logic [3:0] outstanding;
  logic       err_underflow;

  logic vo_man = 1'b0;
  logic loop_en = 1'b0;
  logic vin_d = 1'b0;
  bit   chk_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // stand-in ALU: completes each op two edges after issue
  always @(posedge clk) vin_d <= valid_in;
  assign valid_out = vo_man | (loop_en & vin_d);

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(4), .MAX_OUTST(MAXO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_ctl       (cmd_ctl),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_cin       (cmd_cin),
    .flush         (flush),
    .valid_in      (valid_in),
    .ctl           (ctl),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .valid_out     (valid_out),
    .count         (count),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  alu_cmd_t mq[$];
  alu_cmd_t m_last = '0;
  int       m_out = 0;
  bit       m_err = 1'b0;
  bit       m_vin = 1'b0;

  always @(posedge clk) begin : model
    int n;
    bit acc;
    bit iss;
    if (!reset) begin
      mq.delete();
      m_out  = 0;
      m_err  = 1'b0;
      m_vin  = 1'b0;
      m_last = '0;
    end else begin
      acc = cmd_valid && (mq.size() < DEPTH);
      iss = (mq.size() != 0) && (m_out < MAXO) && !flush;
      m_vin = iss;
      if (iss) m_last = mq.pop_front();
      if (flush) mq.delete();
      else if (acc)
        mq.push_back('{ctl: cmd_ctl, a: cmd_a, b: cmd_b, cin: cmd_cin});
      n = m_out + int'(iss);
      if (valid_out) begin
        if (n == 0) m_err = 1'b1;
        else n--;
      end
      m_out = n;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.valid_in", 32'(valid_in), 32'(m_vin));
      chk("m.ctl", 32'(ctl), 32'(m_last.ctl));
      chk("m.a", 32'(a), 32'(m_last.a));
      chk("m.b", 32'(b), 32'(m_last.b));
      chk("m.cin", 32'(cin), 32'(m_last.cin));
      chk("m.count", 32'(count), 32'(mq.size()));
      chk("m.outstanding", 32'(outstanding), 32'(m_out));
      chk("m.err", 32'(err_underflow), 32'(m_err));
      chk("m.cmd_ready", 32'(cmd_ready),
          32'(reset && (mq.size() < DEPTH)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input opcode_e op, input logic [3:0] av,
                      input logic [3:0] bv, input logic c);
    cmd_valid = 1'b1;
    cmd_ctl   = op;
    cmd_a     = av;
    cmd_b     = bv;
    cmd_cin   = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    loop_en = 1'b0;
    vo_man  = 1'b0;
    reset   = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pulses;
    int issued;
    int exp_a;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst.valid_in", 32'(valid_in), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.outstanding", 32'(outstanding), 0);
    chk("rst.cmd_ready", 32'(cmd_ready), 0);

    // single command latency
    reset = 1'b1;
    push(OP_ADD, 4'd3, 4'd4, 1'b0);
    chk("t1.vin_E", 32'(valid_in), 0);
    chk("t1.count_E", 32'(count), 1);
    tick();
    chk("t1.vin_E1", 32'(valid_in), 1);
    chk("t1.a", 32'(a), 3);
    chk("t1.b", 32'(b), 4);
    chk("t1.count", 32'(count), 0);
    chk("t1.outst", 32'(outstanding), 1);
    tick();
    chk("t1.vin_E2", 32'(valid_in), 0);

    // outstanding cap
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      push(OP_SUB, 4'(i), 4'd1, 1'b0);
      pulses += int'(valid_in);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(valid_in);
    end
    chk("t2.pulses", 32'(pulses), 4);
    chk("t2.outst", 32'(outstanding), 4);
    chk("t2.count", 32'(count), 2);
    vo_man = 1'b1;
    tick();
    vo_man = 1'b0;
    chk("t2.vin_vo", 32'(valid_in), 0);
    chk("t2.outst_vo", 32'(outstanding), 3);
    tick();
    chk("t2.vin_next", 32'(valid_in), 1);
    chk("t2.a_next", 32'(a), 4);
    chk("t2.outst_next", 32'(outstanding), 4);
    tick();
    chk("t2.vin_after", 32'(valid_in), 0);

    // full queue, back-pressure, ordered drain
    do_reset();
    for (int i = 0; i < 4; i++) push(OP_ADD, 4'(i), 4'd1, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) push(OP_AND, 4'(8 + i), 4'(i), 1'(i));
    chk("t3.count_full", 32'(count), 8);
    chk("t3.ready_full", 32'(cmd_ready), 0);
    push(OP_XOR, 4'd0, 4'd0, 1'b0);
    chk("t3.count_9th", 32'(count), 8);
    loop_en = 1'b1;
    vo_man  = 1'b1;
    issued  = 0;
    exp_a   = 8;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) vo_man = 1'b0;
      tick();
      if (valid_in) begin
        chk("t3.order", 32'(a), 32'(exp_a));
        exp_a++;
        issued++;
      end
    end
    chk("t3.issued", 32'(issued), 8);
    chk("t3.count_end", 32'(count), 0);

    // flush beats a same-edge push
    do_reset();
    for (int i = 0; i < 4; i++) push(OP_ADD, 4'(i), 4'd2, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) push(OP_OR, 4'(i + 1), 4'd5, 1'b1);
    chk("t4.count_q", 32'(count), 3);
    flush = 1'b1;
    vo_man = 1'b1;
    push(OP_SUB, 4'd9, 4'd9, 1'b1);
    flush = 1'b0;
    vo_man = 1'b0;
    chk("t4.count_fl", 32'(count), 0);
    chk("t4.vin_fl", 32'(valid_in), 0);
    chk("t4.outst_fl", 32'(outstanding), 3);
    tick();
    chk("t4.vin_next", 32'(valid_in), 0);
    chk("t4.count_next", 32'(count), 0);

    // underflow error and cancelling issue/completion
    do_reset();
    vo_man = 1'b1;
    tick();
    vo_man = 1'b0;
    chk("t5.err", 32'(err_underflow), 1);
    chk("t5.outst0", 32'(outstanding), 0);
    tick();
    chk("t5.err_sticky", 32'(err_underflow), 1);
    push(OP_ADD, 4'd1, 4'd1, 1'b0);
    push(OP_ADD, 4'd2, 4'd2, 1'b0);
    tick();
    chk("t5.outst2", 32'(outstanding), 2);
    push(OP_XOR, 4'd5, 4'd6, 1'b1);
    vo_man = 1'b1;
    tick();
    vo_man = 1'b0;
    chk("t5.vin_both", 32'(valid_in), 1);
    chk("t5.outst_both", 32'(outstanding), 2);
    chk("t5.a_both", 32'(a), 5);

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) push(OP_SHL, 4'(i + 3), 4'd7, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) push(OP_SUB, 4'(i), 4'd3, 1'b0);
    vo_man = 1'b1;
    tick();
    vo_man = 1'b0;
    chk("t6.outst3", 32'(outstanding), 3);
    chk("t6.count5", 32'(count), 5);
    reset = 1'b0;
    tick();
    chk("t6.vin", 32'(valid_in), 0);
    chk("t6.count", 32'(count), 0);
    chk("t6.outst", 32'(outstanding), 0);
    chk("t6.err", 32'(err_underflow), 0);
    chk("t6.ctl", 32'(ctl), 0);
    chk("t6.a", 32'(a), 0);
    chk("t6.b", 32'(b), 0);
    chk("t6.cin", 32'(cin), 0);
    chk("t6.ready", 32'(cmd_ready), 0);
    tick();
    chk("t6.ready_hold", 32'(cmd_ready), 0);
    reset = 1'b1;
    #1;
    chk("t6.ready_rel", 32'(cmd_ready), 1);
    vo_man = 1'b1;
    tick();
    vo_man = 1'b0;
    chk("t6.late_err", 32'(err_underflow), 1);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
